alu_sequencer: RTL

//  Issue/collect controller on the core side of the ALU. It accepts one decoded ALU instruction from the core control FSM.
//  It drives the ALU's decinst, operand and shift-enable inputs and waits for the result: fixed latency for normal ops, sl_ok for shifts.
//  It then returns a write-back value or a branch decision with a one-cycle done pulse. It sits between the instruction decoder/datapath and the ALU.

---
 rtl/alu_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one decoded ALU instruction, waits for the ALU and returns write-back data or a branch decision.
// Optional build macro ALU_SEQ_ZSHIFT_EN: zero-amount shifts bypass the ALU shifter and return rs1 directly.
module alu_sequencer #(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 3,
  parameter int TIMEOUT = 40
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [11:0]     decinst_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            rd_we_o,
  output logic [XLEN-1:0] rd_wdata_o,
  output logic            branch_taken_o,
  output logic            error_o,
  output logic [11:0]     alu_decinst_o,
  output logic [XLEN-1:0] alu_operando1_o,
  output logic [XLEN-1:0] alu_rs2_o,
  output logic [XLEN-1:0] alu_inm_o,
  output logic            alu_en_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_cmp_i,
  input  logic            alu_carry_i,
  input  logic            alu_sl_ok_i
);

  localparam int CntW  = $clog2(ALU_LAT + 1);
  localparam int TcntW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_FIX, S_WAIT_SHIFT, S_SETTLE, S_CAPTURE, S_ERR
  } state_e;

  typedef enum logic [1:0] {CLS_WB, CLS_SHIFT, CLS_BR, CLS_ILL} cls_e;

  // Modifier 2'b01 marks sub/sra/srai; every code outside the 25 ALU operations is illegal.
  function automatic cls_e classify(input logic [11:0] code);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] mods;
    logic       is_shift;
    cls_e       cls;
    opcode   = code[6:0];
    funct3   = code[9:7];
    mods     = code[11:10];
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    cls      = CLS_ILL;
    if (opcode == OPC_OP || opcode == OPC_OPIMM) begin
      if (mods == 2'b00)
        cls = is_shift ? CLS_SHIFT : CLS_WB;
      else if (mods == 2'b01 && funct3 == 3'b101)
        cls = CLS_SHIFT;
      else if (mods == 2'b01 && funct3 == 3'b000 && opcode == OPC_OP)
        cls = CLS_WB;
    end else if (opcode == OPC_BRANCH && mods == 2'b00 && funct3[2:1] != 2'b01) begin
      cls = CLS_BR;
    end
    return cls;
  endfunction

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TcntW-1:0]  tcnt_q, tcnt_d;
  logic [11:0]       decinst_q, decinst_d;
  logic [XLEN-1:0]   op1_q, op1_d;
  logic [XLEN-1:0]   rs2_q, rs2_d;
  logic [XLEN-1:0]   inm_q, inm_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              cmp_q, cmp_d;
  cls_e              cls_q;
  logic              unused_carry;

  assign cls_q        = classify(decinst_q);
  assign unused_carry = alu_carry_i;

`ifdef ALU_SEQ_ZSHIFT_EN
  logic [XLEN-1:0] operand2;
  assign operand2 = (decinst_q[6:0] == OPC_OPIMM) ? inm_q : rs2_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      decinst_q <= '0;
      op1_q     <= '0;
      rs2_q     <= '0;
      inm_q     <= '0;
      wdata_q   <= '0;
      cmp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      decinst_q <= decinst_d;
      op1_q     <= op1_d;
      rs2_q     <= rs2_d;
      inm_q     <= inm_d;
      wdata_q   <= wdata_d;
      cmp_q     <= cmp_d;
    end
  end

  // Results are captured on the edge that enters CAPTURE so they are valid for the whole done cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    decinst_d = decinst_q;
    op1_d     = op1_q;
    rs2_d     = rs2_q;
    inm_d     = inm_q;
    wdata_d   = wdata_q;
    cmp_d     = cmp_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          decinst_d = decinst_i;
          op1_d     = rs1_i;
          rs2_d     = rs2_i;
          inm_d     = imm_i;
          state_d   = (classify(decinst_i) == CLS_ILL) ? S_ERR : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_FIX;
        cnt_d   = CntW'(ALU_LAT - 1);
`ifdef ALU_SEQ_ZSHIFT_EN
        if (cls_q == CLS_SHIFT && operand2[4:0] == 5'd0) begin
          state_d = S_CAPTURE;
          wdata_d = op1_q;
        end
`endif
      end
      S_WAIT_FIX: begin
        if (cnt_q == '0) begin
          if (cls_q == CLS_SHIFT) begin
            state_d = S_WAIT_SHIFT;
            tcnt_d  = '0;
          end else begin
            state_d = S_CAPTURE;
            cmp_d   = alu_cmp_i;
            if (cls_q == CLS_WB) wdata_d = alu_result_i;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      S_WAIT_SHIFT: begin
        if (alu_sl_ok_i)
          state_d = S_SETTLE;
        else if (tcnt_q == TcntW'(TIMEOUT - 1))
          state_d = S_ERR;
        else
          tcnt_d = tcnt_q + TcntW'(1);
      end
      S_SETTLE: begin
        state_d = S_CAPTURE;
        wdata_d = alu_result_i;
      end
      S_CAPTURE, S_ERR: state_d = S_IDLE;
      default:          state_d = S_IDLE;
    endcase
  end

  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = (state_q == S_CAPTURE) || (state_q == S_ERR);
  assign rd_we_o         = (state_q == S_CAPTURE) && (cls_q != CLS_BR);
  assign branch_taken_o  = (state_q == S_CAPTURE) && (cls_q == CLS_BR) && cmp_q;
  assign error_o         = (state_q == S_ERR);
  assign alu_en_o        = (state_q == S_WAIT_SHIFT) || (state_q == S_SETTLE);
  assign rd_wdata_o      = wdata_q;
  assign alu_decinst_o   = decinst_q;
  assign alu_operando1_o = op1_q;
  assign alu_rs2_o       = rs2_q;
  assign alu_inm_o       = inm_q;

endmodule
